// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register-bank blocks:
//   - AXI response codes (OKAY / SLVERR)
//   - write and read FSM state encodings
//   - addr_decode(): maps a byte address to a word index plus an error flag.
//     The index is addr[addr_lsb+3:addr_lsb]. The error flag is set when the
//     index is outside the implemented range or any address bit above the
//     index field is set.
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Addresses are zero-extended to this width before decode so that one
    // function serves every ADDR_W up to 64 bits.
    localparam int unsigned DEC_ADDR_W = 64;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [3:0] idx;
        logic       err;
    } addr_dec_t;

    function automatic addr_dec_t addr_decode(
        input logic [DEC_ADDR_W-1:0] addr,
        input int unsigned           addr_lsb,
        input int unsigned           num_regs
    );
        addr_dec_t             dec;
        logic [DEC_ADDR_W-1:0] word_s;
        word_s  = addr >> addr_lsb;
        dec.idx = word_s[3:0];
        dec.err = (word_s[DEC_ADDR_W-1:4] != 60'd0) ||
                  ({28'd0, word_s[3:0]} >= num_regs);
        return dec;
    endfunction

endpackage

// File: rtl/axi_lite_wr_chan.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_chan
// Write side of the AXI4-Lite register bank: AW/W capture, write FSM and the
// B channel. AW and W are accepted independently; on the edge where both are
// available the write is committed through a one-cycle strobe towards the
// register array and the FSM moves to W_RESP.
//
// Ports:
//   clk, areset             clock, synchronous active-high reset
//   awvalid/awready/awaddr  write address channel
//   wvalid/wready/wdata/wstrb write data channel
//   bvalid/bready/bresp     write response channel
//   wr_en                   commit strobe (only for a decoded, in-range write)
//   wr_idx/wr_data/wr_strb  word index, data and byte enables of the commit
// -----------------------------------------------------------------------------
module axi_lite_wr_chan #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              wr_en,
    output logic [3:0]        wr_idx,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb
);
    import axi_lite_pkg::*;

    wr_state_e             state_r;
    logic                  aw_held_r;
    logic                  w_held_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [31:0]           data_r;
    logic [3:0]            strb_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  aw_have_s;
    logic                  w_have_s;
    logic                  commit_s;
    logic [DEC_ADDR_W-1:0] cmt_addr_s;
    addr_dec_t             cmt_dec_s;

    // Handshake detection and commit source selection (held copy or live bus).
    always_comb begin
        aw_hs_s    = awvalid && awready_r;
        w_hs_s     = wvalid && wready_r;
        aw_have_s  = aw_held_r || aw_hs_s;
        w_have_s   = w_held_r || w_hs_s;
        commit_s   = (state_r == W_IDLE) && aw_have_s && w_have_s;
        cmt_addr_s = {DEC_ADDR_W{1'b0}};
        cmt_addr_s[ADDR_W-1:0] = aw_held_r ? addr_r : awaddr;
        cmt_dec_s  = addr_decode(cmt_addr_s, ADDR_LSB, NUM_REGS);
        wr_en      = commit_s && !cmt_dec_s.err;
        wr_idx     = cmt_dec_s.idx;
        wr_data    = w_held_r ? data_r : wdata;
        wr_strb    = w_held_r ? strb_r : wstrb;
    end

    // Write FSM: capture flags, registered READYs and B channel.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r   <= W_IDLE;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            data_r    <= 32'd0;
            strb_r    <= 4'd0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (state_r)
                W_IDLE: begin
                    if (commit_s) begin
                        state_r   <= W_RESP;
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= cmt_dec_s.err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        if (aw_hs_s) begin
                            aw_held_r <= 1'b1;
                            addr_r    <= awaddr;
                        end
                        if (w_hs_s) begin
                            w_held_r <= 1'b1;
                            data_r   <= wdata;
                            strb_r   <= wstrb;
                        end
                        // READY stays high only for a channel not yet held.
                        awready_r <= !aw_have_s;
                        wready_r  <= !w_have_s;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        state_r   <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= W_IDLE;
                    aw_held_r <= 1'b0;
                    w_held_r  <= 1'b0;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    bresp_r   <= RESP_OKAY;
                end
            endcase
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_regs
// AXI4-Lite slave holding NUM_REGS 32-bit read/write registers with byte
// strobes and SLVERR decode errors. Write and read sides run independently.
// A read on the same edge as a write commit returns the pre-write value.
//
// Ports:
//   ACLK, ARESET                   clock, synchronous active-high reset
//   AW*/W*/B*                      write address/data/response channels
//   AR*/R*                         read address/data channels
//   AWPROT, ARPROT                 accepted and ignored
//   REGS_FLAT                      register i on bits [32*i+31:32*i]
// -----------------------------------------------------------------------------
module axi_lite_slave_regs #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic [2:0]               ARPROT,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   REGS_FLAT
);
    import axi_lite_pkg::*;

    logic [31:0]           regs_r [NUM_REGS];

    logic                  wr_en_s;
    logic [3:0]            wr_idx_s;
    logic [31:0]           wr_data_s;
    logic [3:0]            wr_strb_s;

    rd_state_e             rd_state_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic [1:0]            rresp_r;

    logic [DEC_ADDR_W-1:0] rd_addr_s;
    addr_dec_t             rd_dec_s;
    logic [31:0]           rd_word_s;
    logic                  unused_prot_s;

    assign unused_prot_s = ^{AWPROT, ARPROT};

    axi_lite_wr_chan #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ADDR_LSB (ADDR_LSB)
    ) u_wr_chan (
        .clk     (ACLK),
        .areset  (ARESET),
        .awvalid (AWVALID),
        .awready (AWREADY),
        .awaddr  (AWADDR),
        .wvalid  (WVALID),
        .wready  (WREADY),
        .wdata   (WDATA),
        .wstrb   (WSTRB),
        .bvalid  (BVALID),
        .bready  (BREADY),
        .bresp   (BRESP),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_idx_s),
        .wr_data (wr_data_s),
        .wr_strb (wr_strb_s)
    );

    // Register array: byte-lane update on the commit strobe.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_en_s && (wr_idx_s == 4'(i)) && wr_strb_s[b]) begin
                        regs_r[i][8*b +: 8] <= wr_data_s[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read decode and AND-OR word select (index outside range selects nothing).
    always_comb begin
        rd_addr_s = {DEC_ADDR_W{1'b0}};
        rd_addr_s[ADDR_W-1:0] = ARADDR;
        rd_dec_s  = addr_decode(rd_addr_s, ADDR_LSB, NUM_REGS);
        rd_word_s = 32'd0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            rd_word_s = rd_word_s | ({32{rd_dec_s.idx == 4'(i)}} & regs_r[i]);
        end
    end

    // Read FSM: AR accept, registered R channel held until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ARVALID && arready_r) begin
                        rd_state_r <= R_DATA;
                        arready_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rdata_r    <= rd_dec_s.err ? 32'd0 : rd_word_s;
                        rresp_r    <= rd_dec_s.err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_r  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rd_state_r <= R_IDLE;
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                    rdata_r    <= 32'd0;
                    rresp_r    <= RESP_OKAY;
                end
            endcase
        end
    end

    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RDATA   = rdata_r;
    assign RRESP   = rresp_r;

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign REGS_FLAT[32*g +: 32] = regs_r[g];
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_slave_regs
// Self-checking bench: directed scenarios followed by randomized writes, reads
// and concurrent write+read, compared against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_axi_lite_slave_regs;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 32;
    localparam int ADDR_LSB = 2;

    logic                   ACLK;
    logic                   ARESET;
    logic                   AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic                   ARVALID, ARREADY, RVALID, RREADY;
    logic [ADDR_W-1:0]      AWADDR, ARADDR;
    logic [2:0]             AWPROT, ARPROT;
    logic [31:0]            WDATA, RDATA;
    logic [3:0]             WSTRB;
    logic [1:0]             BRESP, RRESP;
    logic [NUM_REGS*32-1:0] REGS_FLAT;

    int          n_tests;
    int          n_fail;
    logic [31:0] model [NUM_REGS];

    axi_lite_slave_regs #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ADDR_LSB (ADDR_LSB)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .AWVALID (AWVALID), .AWREADY (AWREADY), .AWADDR (AWADDR), .AWPROT (AWPROT),
        .WVALID (WVALID), .WREADY (WREADY), .WDATA (WDATA), .WSTRB (WSTRB),
        .BVALID (BVALID), .BREADY (BREADY), .BRESP (BRESP),
        .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR), .ARPROT (ARPROT),
        .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA), .RRESP (RRESP),
        .REGS_FLAT (REGS_FLAT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] addr);
        return (addr / 32'd4) >= 32'(NUM_REGS);
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = 128'd0;
        for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (!addr_err(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[int'(addr / 32'd4)][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Write with independent AW/W start delays and b_dly cycles of B backpressure.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp, input logic [127:0] exp_flat);
        bit aw_done, w_done, aw_now, w_now;
        int c;
        aw_done = 1'b0; w_done = 1'b0; c = 0;
        BREADY = (b_dly == 0);
        while (!(aw_done && w_done) && c < 50) begin
            AWVALID = !aw_done && (c >= aw_dly);
            AWADDR  = addr;
            AWPROT  = 3'($urandom_range(0, 7));
            WVALID  = !w_done && (c >= w_dly);
            WDATA   = data;
            WSTRB   = strb;
            check_eq("bvalid_before_commit", BVALID, 1'b0);
            aw_now = AWVALID && AWREADY;
            w_now  = WVALID && WREADY;
            tick();
            if (aw_now) aw_done = 1'b1;
            if (w_now)  w_done  = 1'b1;
            if (w_done && !aw_done) check_eq("wready_after_w_held", WREADY, 1'b0);
            if (aw_done && !w_done) check_eq("awready_after_aw_held", AWREADY, 1'b0);
            c++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check_eq("aw_w_handshake_done", aw_done && w_done, 1'b1);
        check_eq("bvalid_after_commit", BVALID, 1'b1);
        check_eq("bresp", BRESP, exp_resp);
        check_eq("regs_flat_after_commit", REGS_FLAT, exp_flat);
        for (int i = 0; i < b_dly; i++) begin
            AWVALID = 1'b1;          // must not be accepted while a response is pending
            AWADDR  = 32'h8;
            tick();
            check_eq("bvalid_held", BVALID, 1'b1);
            check_eq("bresp_held", BRESP, exp_resp);
            check_eq("awready_in_resp", AWREADY, 1'b0);
            check_eq("wready_in_resp", WREADY, 1'b0);
        end
        BREADY = 1'b1;
        tick();
        AWVALID = 1'b0;
        check_eq("bvalid_cleared", BVALID, 1'b0);
        check_eq("readys_after_b", {AWREADY, WREADY}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit done, rdy;
        int c;
        done = 1'b0; c = 0;
        RREADY  = (r_dly == 0);
        ARADDR  = addr;
        ARPROT  = 3'($urandom_range(0, 7));
        ARVALID = 1'b1;
        while (!done && c < 20) begin
            rdy = ARREADY;
            tick();
            if (rdy) done = 1'b1;
            c++;
        end
        ARVALID = 1'b0;
        check_eq("ar_handshake_done", done, 1'b1);
        check_eq("rvalid_latency", RVALID, 1'b1);
        check_eq("rdata", RDATA, exp_data);
        check_eq("rresp", RRESP, exp_resp);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check_eq("rvalid_held", RVALID, 1'b1);
            check_eq("rdata_held", RDATA, exp_data);
            check_eq("rresp_held", RRESP, exp_resp);
            check_eq("arready_in_rdata", ARREADY, 1'b0);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check_eq("rvalid_cleared", RVALID, 1'b0);
        check_eq("arready_after_r", ARREADY, 1'b1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] er;
        er = addr_err(addr) ? 2'b10 : 2'b00;
        model_write(addr, data, strb);
        axi_write(addr, data, strb, aw_dly, w_dly, b_dly, er, model_flat());
    endtask

    task automatic rd(input logic [31:0] addr, input int r_dly);
        logic [31:0] ed;
        logic [1:0]  er;
        ed = addr_err(addr) ? 32'd0 : model[int'(addr / 32'd4)];
        er = addr_err(addr) ? 2'b10 : 2'b00;
        axi_read(addr, r_dly, ed, er);
    endtask

    // Write and read launched on the same edge; the read sees pre-write contents.
    task automatic wr_rd(input logic [31:0] waddr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [31:0] raddr);
        logic [31:0]  ed;
        logic [1:0]   rr, wrsp;
        logic [127:0] ef;
        ed   = addr_err(raddr) ? 32'd0 : model[int'(raddr / 32'd4)];
        rr   = addr_err(raddr) ? 2'b10 : 2'b00;
        wrsp = addr_err(waddr) ? 2'b10 : 2'b00;
        model_write(waddr, data, strb);
        ef = model_flat();
        fork
            axi_write(waddr, data, strb, 0, 0, 0, wrsp, ef);
            axi_read(raddr, 0, ed, rr);
        join
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return 32'($urandom_range(0, NUM_REGS - 1) * 4 + $urandom_range(0, 3));
        else if (sel < 9) return 32'($urandom_range(NUM_REGS, 15) * 4);
        else return 32'($urandom);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        model_clear();
        ARESET = 1'b1;
        AWVALID = 1'b0; AWADDR = 32'd0; AWPROT = 3'd0;
        WVALID = 1'b0; WDATA = 32'd0; WSTRB = 4'd0; BREADY = 1'b0;
        ARVALID = 1'b0; ARADDR = 32'd0; ARPROT = 3'd0; RREADY = 1'b0;
        tick(); tick();
        check_eq("reset_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
        check_eq("reset_valids", {BVALID, RVALID}, 2'b00);
        check_eq("reset_resp_data", {BRESP, RRESP, RDATA}, 36'd0);
        check_eq("reset_regs", REGS_FLAT, 128'd0);
        ARESET = 1'b0;
        tick();
        check_eq("readys_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Single write then read back.
        wr(32'h4, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
        check_eq("reg1_written", REGS_FLAT[63:32], 32'hDEADBEEF);
        rd(32'h4, 0);

        // Strobe merge.
        wr(32'h4, 32'h11223344, 4'b0101, 0, 0, 0);
        check_eq("strobe_merge", REGS_FLAT[63:32], 32'hDE22BE44);
        rd(32'h5, 0);

        // Decode errors and a no-op strobe.
        wr(32'h10, 32'hCAFEF00D, 4'b1111, 1, 0, 0);
        rd(32'hFFFFFFFF, 0);
        wr(32'h4, 32'hFFFFFFFF, 4'b0000, 0, 2, 0);

        // Backpressure on both response channels.
        wr(32'hC, 32'h0BADCAFE, 4'b1111, 0, 0, 5);
        rd(32'hC, 5);
        wr(32'h0, 32'h12345678, 4'b1111, 2, 0, 0);
        check_eq("no_stray_aw_capture", REGS_FLAT[95:64], 32'd0);

        // Read and write to the same register on the same edge.
        wr_rd(32'h4, 32'hA5A5A5A5, 4'b1111, 32'h4);
        rd(32'h4, 0);

        // Reset with BVALID and RVALID pending and an AW offered.
        AWADDR = 32'h8; AWVALID = 1'b1; WDATA = 32'h55AA55AA; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b0;
        tick();
        WVALID = 1'b0;
        AWADDR = 32'h4;
        ARADDR = 32'h0; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        check_eq("pending_b_before_reset", BVALID, 1'b1);
        check_eq("pending_r_before_reset", RVALID, 1'b1);
        ARESET = 1'b1;
        tick();
        AWVALID = 1'b0;
        model_clear();
        check_eq("reset_mid_valids", {BVALID, RVALID}, 2'b00);
        check_eq("reset_mid_regs", REGS_FLAT, 128'd0);
        ARESET = 1'b0;
        tick();
        check_eq("readys_after_mid_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Held AW discarded by reset, then W three cycles before AW.
        AWADDR = 32'h8; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check_eq("aw_held_readys", {AWREADY, WREADY}, 2'b01);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        tick();
        wr(32'h0, 32'h87654321, 4'b1111, 3, 0, 0);
        check_eq("held_aw_discarded", REGS_FLAT[95:64], 32'd0);
        rd(32'h0, 0);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0)
                wr(rand_addr(), 32'($urandom), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else if (op == 1)
                rd(rand_addr(), $urandom_range(0, 2));
            else
                wr_rd(rand_addr(), 32'($urandom), 4'($urandom_range(0, 15)), rand_addr());
        end
        check_eq("final_regs", REGS_FLAT, model_flat());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
